id_ex_reg: RTL and testbench

- ID/EX pipeline register for the 5-stage core, directly upstream of the EX-stage forwarding unit. It supplies id_ex_rs, id_ex_rt, id_ex_rd, id_ex_I_type and id_ex_regwrite to that unit.
- Also owns load-use hazard detection: on a hazard it raises a stall to PC and IF/ID and inserts a bubble into EX.
- Also owns the WB-to-ID same-cycle register bypass and flush handling.
- Keeps a saturating stall counter for performance debug.

---
 rtl/id_ex_reg_pkg.sv | 26 ++
 rtl/load_use_detect.sv | 24 ++
 rtl/id_ex_reg.sv | 126 ++++++++++++
 tb/tb_id_ex_reg.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_reg_pkg.sv
// Shared pipeline definitions: default widths, control bundle layout and
// forwarding select encodings used across the ID/EX/MEM/WB stages.
package id_ex_reg_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_W  = 5;
  localparam int DEF_CTRL_W = 8;
  localparam int DEF_CNT_W  = 16;

  // Bit offsets of the fields packed into the opaque control bundle.
  localparam int CTRL_ALU_OP_LSB = 0;
  localparam int CTRL_ALU_OP_W   = 4;
  localparam int CTRL_ALU_SRC    = 4;
  localparam int CTRL_MEM_WRITE  = 5;
  localparam int CTRL_BRANCH     = 6;
  localparam int CTRL_MEM_TO_REG = 7;

  localparam logic [DEF_REG_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    FWD_REGFILE = 2'b00,
    FWD_EX_MEM  = 2'b01,
    FWD_MEM_WB  = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/load_use_detect.sv
// Pure combinational load-use hazard equation between the instruction in ID
// and a load currently sitting in EX.
module load_use_detect
  import id_ex_reg_pkg::*;
#(
  parameter int REG_W = DEF_REG_W
) (
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_I_type,
  input  logic             ex_valid,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  output logic             hazard
);

  localparam logic [REG_W-1:0] ZERO = REG_W'(REG_ZERO);

  // I-type instructions use rt as a destination, so only rs can collide.
  assign hazard = id_valid & ex_valid & ex_memread & (ex_rd != ZERO) &
                  ((ex_rd == id_rs) | (!id_I_type & (ex_rd == id_rt)));

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use stall, flush bubbles, WB-to-ID
// same-cycle bypass and a saturating stall counter.
module id_ex_reg
  import id_ex_reg_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_W  = DEF_REG_W,
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_I_type,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              wb_regwrite,
  input  logic [REG_W-1:0]  wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              id_stall,
  output logic              id_ex_valid,
  output logic [REG_W-1:0]  id_ex_rs,
  output logic [REG_W-1:0]  id_ex_rt,
  output logic [REG_W-1:0]  id_ex_rd,
  output logic [DATA_W-1:0] id_ex_rs_data,
  output logic [DATA_W-1:0] id_ex_rt_data,
  output logic [DATA_W-1:0] id_ex_imm,
  output logic [CTRL_W-1:0] id_ex_ctrl,
  output logic              id_ex_I_type,
  output logic              id_ex_regwrite,
  output logic              id_ex_memread,
  output logic [CNT_W-1:0]  stall_count
);

  localparam logic [REG_W-1:0] ZERO    = REG_W'(REG_ZERO);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              hazard;
  logic              bubble;
  logic              rs_bypass;
  logic              rt_bypass;
  logic [DATA_W-1:0] rs_data_in;
  logic [DATA_W-1:0] rt_data_in;

  load_use_detect #(
    .REG_W (REG_W)
  ) u_load_use_detect (
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_I_type  (id_I_type),
    .ex_valid   (id_ex_valid),
    .ex_memread (id_ex_memread),
    .ex_rd      (id_ex_rd),
    .hazard     (hazard)
  );

  // A flush kills the ID instruction, so a coincident hazard must not stall.
  assign id_stall = hazard & !flush;
  assign bubble   = flush | hazard;

  // Regfile is written in WB and read in ID in the same cycle; take WB data.
  always_comb begin
    rs_bypass  = wb_regwrite && (wb_rd != ZERO) && (wb_rd == id_rs);
    rt_bypass  = wb_regwrite && (wb_rd != ZERO) && (wb_rd == id_rt);
    rs_data_in = rs_bypass ? wb_data : id_rs_data;
    rt_data_in = rt_bypass ? wb_data : id_rt_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_ex_valid    <= 1'b0;
      id_ex_rs       <= '0;
      id_ex_rt       <= '0;
      id_ex_rd       <= '0;
      id_ex_rs_data  <= '0;
      id_ex_rt_data  <= '0;
      id_ex_imm      <= '0;
      id_ex_ctrl     <= '0;
      id_ex_I_type   <= 1'b0;
      id_ex_regwrite <= 1'b0;
      id_ex_memread  <= 1'b0;
    end else if (bubble) begin
      id_ex_valid    <= 1'b0;
      id_ex_rs       <= '0;
      id_ex_rt       <= '0;
      id_ex_rd       <= '0;
      id_ex_rs_data  <= '0;
      id_ex_rt_data  <= '0;
      id_ex_imm      <= '0;
      id_ex_ctrl     <= '0;
      id_ex_I_type   <= 1'b0;
      id_ex_regwrite <= 1'b0;
      id_ex_memread  <= 1'b0;
    end else begin
      id_ex_valid    <= id_valid;
      id_ex_rs       <= id_rs;
      id_ex_rt       <= id_rt;
      id_ex_rd       <= id_rd;
      id_ex_rs_data  <= rs_data_in;
      id_ex_rt_data  <= rt_data_in;
      id_ex_imm      <= id_imm;
      id_ex_ctrl     <= id_ctrl;
      id_ex_I_type   <= id_I_type;
      id_ex_regwrite <= id_regwrite;
      id_ex_memread  <= id_memread;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (id_stall && (stall_count != CNT_MAX)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed bench for id_ex_reg; a second instance with a narrow counter
// exercises stall_count saturation within a short run.
module tb_id_ex_reg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int CTRL_W = 8;
  localparam int CNT_W  = 16;
  localparam int SAT_W  = 6;

  logic              clk;
  logic              rst_n;
  logic              id_valid;
  logic [REG_W-1:0]  id_rs;
  logic [REG_W-1:0]  id_rt;
  logic [REG_W-1:0]  id_rd;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic [DATA_W-1:0] id_imm;
  logic [CTRL_W-1:0] id_ctrl;
  logic              id_I_type;
  logic              id_regwrite;
  logic              id_memread;
  logic              wb_regwrite;
  logic [REG_W-1:0]  wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              flush;

  logic              id_stall;
  logic              id_ex_valid;
  logic [REG_W-1:0]  id_ex_rs;
  logic [REG_W-1:0]  id_ex_rt;
  logic [REG_W-1:0]  id_ex_rd;
  logic [DATA_W-1:0] id_ex_rs_data;
  logic [DATA_W-1:0] id_ex_rt_data;
  logic [DATA_W-1:0] id_ex_imm;
  logic [CTRL_W-1:0] id_ex_ctrl;
  logic              id_ex_I_type;
  logic              id_ex_regwrite;
  logic              id_ex_memread;
  logic [CNT_W-1:0]  stall_count;

  logic              s_id_stall;
  logic              s_id_ex_valid;
  logic [REG_W-1:0]  s_id_ex_rs;
  logic [REG_W-1:0]  s_id_ex_rt;
  logic [REG_W-1:0]  s_id_ex_rd;
  logic [DATA_W-1:0] s_id_ex_rs_data;
  logic [DATA_W-1:0] s_id_ex_rt_data;
  logic [DATA_W-1:0] s_id_ex_imm;
  logic [CTRL_W-1:0] s_id_ex_ctrl;
  logic              s_id_ex_I_type;
  logic              s_id_ex_regwrite;
  logic              s_id_ex_memread;
  logic [SAT_W-1:0]  s_stall_count;

  int compared   = 0;
  int mismatched = 0;
  logic prev_stall = 1'b0;

  id_ex_reg dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .id_I_type(id_I_type), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .id_stall(id_stall), .id_ex_valid(id_ex_valid), .id_ex_rs(id_ex_rs),
    .id_ex_rt(id_ex_rt), .id_ex_rd(id_ex_rd), .id_ex_rs_data(id_ex_rs_data),
    .id_ex_rt_data(id_ex_rt_data), .id_ex_imm(id_ex_imm), .id_ex_ctrl(id_ex_ctrl),
    .id_ex_I_type(id_ex_I_type), .id_ex_regwrite(id_ex_regwrite),
    .id_ex_memread(id_ex_memread), .stall_count(stall_count)
  );

  id_ex_reg #(.CNT_W(SAT_W)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .id_I_type(id_I_type), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .id_stall(s_id_stall), .id_ex_valid(s_id_ex_valid), .id_ex_rs(s_id_ex_rs),
    .id_ex_rt(s_id_ex_rt), .id_ex_rd(s_id_ex_rd), .id_ex_rs_data(s_id_ex_rs_data),
    .id_ex_rt_data(s_id_ex_rt_data), .id_ex_imm(s_id_ex_imm), .id_ex_ctrl(s_id_ex_ctrl),
    .id_ex_I_type(s_id_ex_I_type), .id_ex_regwrite(s_id_ex_regwrite),
    .id_ex_memread(s_id_ex_memread), .stall_count(s_stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd, input logic [31:0] rs_d,
                               input logic [31:0] rt_d, input logic [31:0] imm,
                               input logic [7:0] ctrl, input logic itype,
                               input logic rw, input logic mr);
    id_valid    = v;
    id_rs       = rs;
    id_rt       = rt;
    id_rd       = rd;
    id_rs_data  = rs_d;
    id_rt_data  = rt_d;
    id_imm      = imm;
    id_ctrl     = ctrl;
    id_I_type   = itype;
    id_regwrite = rw;
    id_memread  = mr;
    #1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Holding a self-dependent load in ID alternates hazard and capture cycles.
  task automatic runLoads(input int cycles, input logic first_stall);
    for (int i = 0; i < cycles; i++) begin
      checkOutput("loop_stall", {31'b0, id_stall}, {31'b0, first_stall ^ i[0]});
      nextCycle();
    end
  endtask

  // A load-use stall must never persist for two consecutive cycles.
  always @(negedge clk) begin
    if (rst_n) begin
      compared++;
      assert (!(prev_stall && id_stall)) else begin
        mismatched++;
        $error("[TB] FAIL stall_run: observed two consecutive stall cycles, expected at most one");
      end
      prev_stall <= id_stall;
    end else begin
      prev_stall <= 1'b0;
    end
  end

  initial begin
    #5000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    wb_regwrite = 1'b0;
    wb_rd = '0;
    wb_data = '0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
    #2;
    checkOutput("rst_valid", {31'b0, id_ex_valid}, 0);
    checkOutput("rst_rd", {27'b0, id_ex_rd}, 0);
    checkOutput("rst_count", {16'b0, stall_count}, 0);
    checkOutput("rst_stall", {31'b0, id_stall}, 0);
    nextCycle();
    rst_n = 1'b1;

    // lw r5,0(r1) then add r7,r5,r2
    applyStimulus(1, 1, 5, 5, 32'h10, 32'h0, 32'h0, 8'h11, 1, 1, 1);
    checkOutput("lw_nostall", {31'b0, id_stall}, 0);
    nextCycle();
    checkOutput("lw_memread", {31'b0, id_ex_memread}, 1);
    checkOutput("lw_rd", {27'b0, id_ex_rd}, 5);
    applyStimulus(1, 5, 2, 7, 32'h100, 32'h200, 32'h0, 8'h21, 0, 1, 0);
    checkOutput("add_stall", {31'b0, id_stall}, 1);
    nextCycle();
    checkOutput("bub_valid", {31'b0, id_ex_valid}, 0);
    checkOutput("bub_regwrite", {31'b0, id_ex_regwrite}, 0);
    checkOutput("bub_ctrl", {24'b0, id_ex_ctrl}, 0);
    checkOutput("bub_count", {16'b0, stall_count}, 1);
    checkOutput("bub_stall_off", {31'b0, id_stall}, 0);
    nextCycle();
    checkOutput("add_valid", {31'b0, id_ex_valid}, 1);
    checkOutput("add_rs", {27'b0, id_ex_rs}, 5);
    checkOutput("add_rt_data", id_ex_rt_data, 32'h200);
    checkOutput("add_ctrl", {24'b0, id_ex_ctrl}, 32'h21);

    // addi r5,r3,4 style: rt collides but is ignored for I-type
    applyStimulus(1, 1, 5, 5, 32'h10, 32'h0, 32'h0, 8'h11, 1, 1, 1);
    nextCycle();
    applyStimulus(1, 3, 5, 5, 32'h0, 32'h0, 32'h4, 8'h12, 1, 1, 0);
    checkOutput("itype_rt_nostall", {31'b0, id_stall}, 0);
    nextCycle();
    checkOutput("itype_rs", {27'b0, id_ex_rs}, 3);
    checkOutput("itype_imm", id_ex_imm, 32'h4);
    checkOutput("itype_count", {16'b0, stall_count}, 1);
    applyStimulus(1, 1, 5, 5, 32'h10, 32'h0, 32'h0, 8'h11, 1, 1, 1);
    nextCycle();
    applyStimulus(1, 5, 5, 5, 32'h0, 32'h0, 32'h4, 8'h12, 1, 1, 0);
    checkOutput("itype_rs_stall", {31'b0, id_stall}, 1);
    nextCycle();
    checkOutput("itype_bub_count", {16'b0, stall_count}, 2);
    nextCycle();
    checkOutput("itype_capture_rs", {27'b0, id_ex_rs}, 5);

    // load to r0 followed by reader of r0
    applyStimulus(1, 1, 0, 0, 32'h10, 32'h0, 32'h0, 8'h11, 1, 1, 1);
    nextCycle();
    applyStimulus(1, 0, 0, 7, 32'h0, 32'h0, 32'h0, 8'h21, 0, 1, 0);
    checkOutput("r0_nostall", {31'b0, id_stall}, 0);
    nextCycle();
    checkOutput("r0_count", {16'b0, stall_count}, 2);
    checkOutput("r0_valid", {31'b0, id_ex_valid}, 1);

    // flush coincident with a hazard
    applyStimulus(1, 1, 5, 5, 32'h10, 32'h0, 32'h0, 8'h11, 1, 1, 1);
    nextCycle();
    flush = 1'b1;
    applyStimulus(1, 5, 2, 7, 32'h100, 32'h200, 32'h0, 8'h21, 0, 1, 0);
    checkOutput("flush_stall", {31'b0, id_stall}, 0);
    nextCycle();
    flush = 1'b0;
    checkOutput("flush_valid", {31'b0, id_ex_valid}, 0);
    checkOutput("flush_rd", {27'b0, id_ex_rd}, 0);
    checkOutput("flush_count", {16'b0, stall_count}, 2);

    // WB same-cycle bypass
    wb_regwrite = 1'b1;
    wb_rd = 5'd9;
    wb_data = 32'hDEADBEEF;
    applyStimulus(1, 9, 9, 7, 32'h0, 32'h0, 32'h0, 8'h21, 0, 1, 0);
    nextCycle();
    checkOutput("byp_rs", id_ex_rs_data, 32'hDEADBEEF);
    checkOutput("byp_rt", id_ex_rt_data, 32'hDEADBEEF);
    wb_rd = 5'd0;
    applyStimulus(1, 0, 0, 7, 32'h1234, 32'h5678, 32'h0, 8'h21, 0, 1, 0);
    nextCycle();
    checkOutput("byp_r0_rs", id_ex_rs_data, 32'h1234);
    checkOutput("byp_r0_rt", id_ex_rt_data, 32'h5678);
    wb_rd = 5'd9;
    applyStimulus(1, 3, 9, 7, 32'h11, 32'h0, 32'h0, 8'h21, 0, 1, 0);
    nextCycle();
    checkOutput("byp_rt_only_rs", id_ex_rs_data, 32'h11);
    checkOutput("byp_rt_only_rt", id_ex_rt_data, 32'hDEADBEEF);
    wb_regwrite = 1'b0;

    // lw r5,0(r5) held in ID: 61 stalls bring the count to 63
    applyStimulus(1, 5, 5, 5, 32'h0, 32'h0, 32'h0, 8'h11, 1, 1, 1);
    runLoads(123, 1'b0);
    checkOutput("sat_reach", {26'b0, s_stall_count}, 63);
    checkOutput("cnt_63", {16'b0, stall_count}, 63);
    runLoads(18, 1'b1);
    checkOutput("sat_hold", {26'b0, s_stall_count}, 63);
    checkOutput("cnt_72", {16'b0, stall_count}, 72);

    // asynchronous reset in the middle of a stall
    checkOutput("pre_rst_stall", {31'b0, id_stall}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", {31'b0, id_ex_valid}, 0);
    checkOutput("mid_rst_memread", {31'b0, id_ex_memread}, 0);
    checkOutput("mid_rst_rd", {27'b0, id_ex_rd}, 0);
    checkOutput("mid_rst_count", {16'b0, stall_count}, 0);
    checkOutput("mid_rst_sat", {26'b0, s_stall_count}, 0);
    checkOutput("mid_rst_stall", {31'b0, id_stall}, 0);
    nextCycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
